instr_sequencer: RTL

- Instruction source for the processor core. It owns a small writable program memory and a program counter, and issues 8-bit instructions to the processor's instruction input through a valid/ready handshake.
- It executes its own flow-control instructions (halt, jump, jump-if-zero) internally and never forwards them to the core.
- It samples the core's zero_flag to resolve conditional jumps.

---
 rtl/instr_sequencer_pkg.sv | 41 ++++
 rtl/instr_sequencer_mem.sv | 26 ++
 rtl/instr_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared types and opcode constants for the instruction sequencer and its program memory.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    SETTLE
  } seq_state_e;

  typedef enum logic [1:0] {
    OPK_HALT,
    OPK_JMP,
    OPK_JZ,
    OPK_CORE
  } op_kind_e;

  localparam logic [7:0] OP_HALT   = 8'h00;
  localparam logic [3:0] OP_JMP_HI = 4'h0;
  localparam logic [3:0] OP_JZ_HI  = 4'hF;

  // Core ALU opcode nibbles (upper nibble of an issued instruction).
  localparam logic [3:0] ALU_ADD = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_AND = 4'h3;
  localparam logic [3:0] ALU_OR  = 4'h4;
  localparam logic [3:0] ALU_XOR = 4'h5;
  localparam logic [3:0] ALU_LDI = 4'h6;
  localparam logic [3:0] ALU_MOV = 4'h7;

  function automatic op_kind_e decode_op(input logic [7:0] op);
    op_kind_e kind;
    if (op == OP_HALT)              kind = OPK_HALT;
    else if (op[7:4] == OP_JMP_HI)  kind = OPK_JMP;
    else if (op[7:4] == OP_JZ_HI)   kind = OPK_JZ;
    else                            kind = OPK_CORE;
    return kind;
  endfunction

endpackage

// File: rtl/instr_sequencer_mem.sv
// Program store: synchronous-write, registered-read RAM; contents survive reset.
module instr_mem #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned INSTR_W = 8
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic               re_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches from program RAM, executes HALT/JMP/JZ locally,
// and issues all other opcodes to the core over a valid/ready handshake.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned INSTR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               zero_flag,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done
);

  seq_state_e         state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;
  logic               z_q;
  logic [INSTR_W-1:0] mem_rdata;
  logic [ADDR_W-1:0]  target;
  logic [ADDR_W-1:0]  pc_inc;

  instr_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_mem (
    .clk    (clk),
    .we_i   (prog_we && !busy_q),
    .waddr_i(prog_addr),
    .wdata_i(prog_data),
    .re_i   (state_q == FETCH),
    .raddr_i(pc_q),
    .rdata_o(mem_rdata)
  );

  assign target = ADDR_W'(mem_rdata[3:0]);
  assign pc_inc = pc_q + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            pc_q    <= '0;
            busy_q  <= 1'b1;
            z_q     <= 1'b0;
            state_q <= FETCH;
          end
        end
        FETCH: state_q <= DECODE;
        DECODE: begin
          unique case (decode_op(mem_rdata))
            OPK_HALT: begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
            OPK_JMP: begin
              pc_q    <= target;
              state_q <= FETCH;
            end
            OPK_JZ: begin
              pc_q    <= z_q ? target : pc_inc;
              state_q <= FETCH;
            end
            default: begin
              instr_q <= mem_rdata;
              valid_q <= 1'b1;
              state_q <= ISSUE;
            end
          endcase
        end
        ISSUE: begin
          if (instr_ready) begin
            valid_q <= 1'b0;
            pc_q    <= pc_inc;
            state_q <= SETTLE;
          end
        end
        // Core registers the opcode at issue, so its flag is ready one cycle later.
        SETTLE: begin
          z_q     <= zero_flag;
          state_q <= FETCH;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
